// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: font table, off pattern and polarity helper for the seven-segment scanner
package seven_seg_pkg;
    localparam logic [6:0] SEG_OFF_LOW = 7'b1111111;
    localparam logic [6:0] FONT_LOW [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
    };
    function automatic logic [6:0] pol7(input logic [6:0] v, input bit active_low);
        return active_low ? v : ~v;
    endfunction
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-low seven-segment font lookup
module hex_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = FONT_LOW[nib];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: N-digit multiplexed display driver with double-buffered load,
// per-digit dp/blanking, leading-zero suppression and selectable pin polarity
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1024,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    pending,
    output logic                    frame_done
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);

    typedef struct packed {
        logic                    lz_en;
        logic [NUM_DIGITS-1:0]   blank;
        logic [NUM_DIGITS-1:0]   dp;
        logic [4*NUM_DIGITS-1:0] value;
    } frame_t;

    frame_t                pend_q, disp_q, disp_n;
    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx, idx_n;
    logic                  tick, wrap, commit, lit, zero_above;
    logic [NUM_DIGITS-1:0] dark, an_n;
    logic [3:0]            nib;
    logic [6:0]            font;

    assign tick   = pcnt == PW'(SCAN_DIV - 1);
    assign wrap   = tick && idx == IW'(NUM_DIGITS - 1);
    assign commit = wrap && pending;
    assign idx_n  = wrap ? '0 : idx + 1'b1;
    // outputs must reflect a commit landing on the same edge
    assign disp_n = commit ? pend_q : disp_q;
    assign nib    = disp_n.value[{idx_n, 2'b00} +: 4];
    assign lit    = !dark[idx_n];
    assign an_n   = lit ? NUM_DIGITS'(1) << idx_n : '0;

    always_comb begin
        dark = disp_n.blank;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && disp_n.value[4*i +: 4] == 4'd0;
            dark[i] = dark[i] | (disp_n.lz_en & zero_above);
        end
    end

    hex_to_seg7 u_font (.nib(nib), .seg(font));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt       <= '0;
            idx        <= IW'(NUM_DIGITS - 1);
            pend_q     <= '0;
            disp_q     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an         <= {NUM_DIGITS{ACTIVE_LOW}};
            seg        <= pol7(SEG_OFF_LOW, ACTIVE_LOW);
            dp         <= ACTIVE_LOW;
        end else begin
            pcnt       <= tick ? '0 : pcnt + 1'b1;
            frame_done <= wrap;
            if (load) begin
                pend_q  <= {lz_en, blank_mask, dp_mask, value};
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            if (commit) disp_q <= pend_q;
            if (tick) begin
                idx <= idx_n;
                an  <= ACTIVE_LOW ? ~an_n : an_n;
                seg <= pol7(lit ? font : SEG_OFF_LOW, ACTIVE_LOW);
                dp  <= ACTIVE_LOW ? !(lit && disp_n.dp[idx_n]) : (lit && disp_n.dp[idx_n]);
            end
        end
    end
endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. It replaces the fixed 3-digit scanner. Adds a double-buffered load handshake, per-digit decimal point and blanking, leading-zero suppression, and selectable output polarity. It sits between datapath registers (counters, ALU results) and the board's anode/segment pins.

## Interface
- NUM_DIGITS, 8: number of digits scanned, 2..16
- SCAN_DIV, 1024: clk cycles each digit is lit, ≥2
- ACTIVE_LOW, 1: 1 means an/seg/dp pins are active-low; 0 means active-high
- clk  in  1  system clock
- rst  in  1  reset; asynchronous and active-high
- load  in  1  single-cycle strobe; captures value/dp_mask/blank_mask/lz_en
- value  in  4*NUM_DIGITS  hex nibbles; nibble i (value[4i+3:4i]) drives digit i, where digit 0 is rightmost
- dp_mask  in  NUM_DIGITS  bit i lights the decimal point of digit i
- blank_mask  in  NUM_DIGITS  bit i forces digit i dark
- lz_en  in  1  enable leading-zero suppression
- an  out  NUM_DIGITS  anode enables; an[i] selects digit i
- seg  out  7  segments; seg[6]=a … seg[0]=g
- dp  out  1  decimal point segment
- pending  out  1  loaded data is waiting for the next frame boundary
- frame_done  out  1  one-cycle pulse when the scan wraps to digit 0

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps. `tick` is asserted when pcnt==SCAN_DIV-1.
- Digit index `idx` advances only on `tick`, as idx_next = (idx==NUM_DIGITS-1) ? 0 : idx+1.
- Wrap tick is a tick where idx==NUM_DIGITS-1.
- Pending buffer:
  - `load` writes value/masks/lz_en into the pending register and sets `pending`.
  - A load while pending is already set overwrites the pending register; the latest load wins.
- Commit: on a wrap tick with pending=1, the pending register is copied to the display register and pending is cleared.
- Load coincident with a wrap tick:
  - The commit uses the old pending contents.
  - The new data goes to the pending register, and pending stays 1.
  - If pending was 0, nothing is committed and pending becomes 1.
- Leading-zero suppression applies to the display register. Digit i (i≥1) is dark when all of these hold:
  - lz_en=1
  - nibble i = 0
  - every nibble j>i = 0
- Digit 0 is never suppressed.
- A dark digit (blanked or suppressed) has its anode inactive, all segments off and dp off.
- A lit digit shows:
  - exactly one anode active
  - the seg font for its nibble
  - dp = dp_mask bit
- Font (active-low form, inverted when ACTIVE_LOW=0):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000
  - c=1110010, d=1000010, E=0110000, F=0111000
- Inactive level is 1 when ACTIVE_LOW=1 and 0 when ACTIVE_LOW=0.

## Timing
- Reset (async assert, synchronous release):
  - pcnt=0; idx=NUM_DIGITS-1
  - display register and pending register zero; pending=0
  - frame_done=0
  - an, seg and dp at inactive level
- First tick comes SCAN_DIV cycles after reset release. It is a wrap tick, so idx becomes 0 and frame_done pulses.
- an, seg and dp are registered and update on the tick edge.
  - They show digit idx_next using the display register as it stands after any commit on that same edge.
  - The new frame's digit 0 therefore already reflects committed data.
- frame_done is registered: high for exactly the one cycle following a wrap tick edge. Period is NUM_DIGITS*SCAN_DIV cycles.
- Load-to-display latency: from 1 cycle up to NUM_DIGITS*SCAN_DIV cycles, depending on scan phase. pending is observable the cycle after load.
- Inputs are sampled only on the load cycle. Changes at any other time have no effect.
- Reset mid-frame: outputs go inactive immediately, pending data is discarded, and the scan restarts as after power-up.

## Structure
- Package `seven_seg_pkg` holds:
  - the 16-entry active-low font constant array
  - SEG_OFF_LOW = 7'b1111111
  - a polarity helper function applying ACTIVE_LOW
- Sub-module `hex_to_seg7`: combinational 4-bit to 7-bit font lookup from the package, instantiated once on the muxed nibble.
- Top level holds:
  - prescaler
  - idx counter
  - pending/display registers
  - LZ mask logic (priority scan from the MSB)
  - output registers

## Test plan
- Reset and first frame (NUM_DIGITS=4, SCAN_DIV=4):
  - After reset, an=1111, seg=1111111, dp=1 for 4 cycles.
  - Then frame_done pulses and an=1110 with seg=0000001 (digit 0, value 0).
- Load mid-frame:
  - Load value=16'h12AF while idx=1 → pending=1 and the display is unchanged.
  - At the next wrap, pending=0 and the digits show F, A, 2, 1 on an=1110, 1101, 1011, 0111.
- Double load and simultaneous load:
  - Load 16'h1111, then 16'h2222 before the wrap → only 2222 is displayed.
  - Load 16'h3333 on the wrap-tick cycle → 2222 commits, pending stays 1, and 3333 appears at the following wrap.
- Leading-zero suppression:
  - value=16'h0050 with lz_en=1 → digits 3 and 2 dark (an stays 1111 in their slots); digits 1 and 0 show 5 and 0.
  - value=16'h0000 → only digit 0 lit, showing 0.
- Masks and polarity:
  - dp_mask=4'b0100 with blank_mask=4'b0001 → dp=0 only in the digit 2 slot, and digit 0 is dark.
  - Repeat with ACTIVE_LOW=0 → all outputs are the bitwise inverse.
- Reset mid-operation: assert rst during digit 2 with pending=1 → outputs go inactive in the same cycle, and after release pending=0 and the display register is zero.
